// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: state encodings, opcodes and ALU select codes shared by the multicycle datapath.
package multicycle_control_pkg;
  localparam logic [3:0] S_FETCH    = 4'b0000;
  localparam logic [3:0] S_DECODE   = 4'b0001;
  localparam logic [3:0] S_MEMADR   = 4'b0010;
  localparam logic [3:0] S_MEMREAD  = 4'b0011;
  localparam logic [3:0] S_MEMWRITE = 4'b0100;
  localparam logic [3:0] S_EXECUTE  = 4'b0101;
  localparam logic [3:0] S_ALUWB    = 4'b0110;
  localparam logic [3:0] S_MEMWB    = 4'b0111;
  localparam logic [3:0] S_BRANCH   = 4'b1000;
  localparam logic [3:0] S_HALT     = 4'b1001;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUSRCB_REG  = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM  = 2'b10;
  function automatic logic is_legal(input logic [6:0] op);
    return op inside {OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH};
  endfunction
endpackage

// File: rtl/multicycle_control_outputs.sv
// control_outputs: Moore strobe decode of the registered control state; unreachable codes give all-zero strobes.
module control_outputs
  import multicycle_control_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       is_imm_i,
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       run_i,
  output logic       pcwrite_o,
  output logic       pcwrite_br_o,
  output logic       irwrite_o,
  output logic       memread_o,
  output logic       memwrite_o,
  output logic       regiwrite_o,
  output logic       memtoreg_o,
  output logic [1:0] alusrcb_o,
  output logic [1:0] aluop_o,
  output logic       halted_o
);
  logic fetch;
  logic branch;
  logic execute;
  assign fetch   = state_i == S_FETCH && run_i;
  assign branch  = state_i == S_BRANCH;
  assign execute = state_i == S_EXECUTE;
  always_comb begin
    pcwrite_o    = fetch;
    irwrite_o    = fetch;
    memread_o    = fetch || state_i == S_MEMREAD;
    memwrite_o   = state_i == S_MEMWRITE;
    regiwrite_o  = state_i == S_ALUWB || state_i == S_MEMWB;
    memtoreg_o   = state_i == S_MEMWB;
    halted_o     = state_i == S_HALT;
    pcwrite_br_o = branch && ((funct3_i == 3'b000 && zero_i) || (funct3_i == 3'b001 && !zero_i));
    alusrcb_o    = fetch ? ALUSRCB_FOUR :
                   (state_i == S_MEMADR || (execute && is_imm_i)) ? ALUSRCB_IMM : ALUSRCB_REG;
    aluop_o      = execute ? ALUOP_FUNCT : branch ? ALUOP_SUB : ALUOP_ADD;
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the multicycle RV32I-subset datapath, with retire counter and illegal-opcode halt.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int COUNT_W         = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic               zero,
  output logic [3:0]         state,
  output logic               pcwrite,
  output logic               pcwrite_br,
  output logic               irwrite,
  output logic               memread,
  output logic               memwrite,
  output logic               regiwrite,
  output logic               memtoreg,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic               halted,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);
  logic [3:0]         state_q, state_d;
  logic               is_imm_q;
  logic               illegal_q;
  logic [COUNT_W-1:0] count_q;
  logic               retire;
  always_ff @(posedge clk) state_q <= rst ? S_FETCH : state_d;
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:   state_d = run ? S_DECODE : S_FETCH;
      S_DECODE:  state_d = (opcode == OP_LOAD || opcode == OP_STORE) ? S_MEMADR :
                           (opcode == OP_RTYPE || opcode == OP_ITYPE) ? S_EXECUTE :
                           opcode == OP_BRANCH ? S_BRANCH :
                           HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
      S_MEMADR:  state_d = opcode == OP_LOAD ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end
  // these four states are the only final states of a legal instruction
  assign retire = state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH};
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      illegal_q <= 1'b0;
      is_imm_q  <= 1'b0;
    end else begin
      if (retire) count_q <= count_q + COUNT_W'(1);
      if (state_q == S_DECODE && (opcode == OP_RTYPE || opcode == OP_ITYPE)) is_imm_q <= opcode == OP_ITYPE;
      if (state_q == S_DECODE && state_d == S_HALT) illegal_q <= 1'b1;
    end
  end
  control_outputs u_outputs (
    .state_i     (state_q),
    .is_imm_i    (is_imm_q),
    .funct3_i    (funct3),
    .zero_i      (zero),
    .run_i       (run),
    .pcwrite_o   (pcwrite),
    .pcwrite_br_o(pcwrite_br),
    .irwrite_o   (irwrite),
    .memread_o   (memread),
    .memwrite_o  (memwrite),
    .regiwrite_o (regiwrite),
    .memtoreg_o  (memtoreg),
    .alusrcb_o   (alusrcb),
    .aluop_o     (aluop),
    .halted_o    (halted)
  );
  assign state       = state_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction streams against an instruction-level model, on a halting 32-bit build and a NOP-on-illegal 4-bit build.
module tb_multicycle_control;
  typedef logic [3:0] sq_t[$];
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, zero = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic [3:0] state, state2;
  logic pcwrite, pcwrite_br, irwrite, memread, memwrite, regiwrite, memtoreg, halted, illegal;
  logic pcwrite2, pcwrite_br2, irwrite2, memread2, memwrite2, regiwrite2, memtoreg2, halted2, illegal2;
  logic [1:0] alusrcb, aluop, alusrcb2, aluop2;
  logic [31:0] instr_count;
  logic [3:0] count2;
  logic [11:0] sig, sig2;
  int checks = 0, errors = 0;
  longint model_cnt = 0;
  always #5 clk = ~clk;
  assign sig  = {pcwrite, pcwrite_br, irwrite, memread, memwrite, regiwrite, memtoreg, alusrcb, aluop, halted};
  assign sig2 = {pcwrite2, pcwrite_br2, irwrite2, memread2, memwrite2, regiwrite2, memtoreg2, alusrcb2, aluop2, halted2};
  multicycle_control dut (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3), .zero(zero),
    .state(state), .pcwrite(pcwrite), .pcwrite_br(pcwrite_br), .irwrite(irwrite),
    .memread(memread), .memwrite(memwrite), .regiwrite(regiwrite), .memtoreg(memtoreg),
    .alusrcb(alusrcb), .aluop(aluop), .halted(halted), .illegal(illegal), .instr_count(instr_count)
  );
  multicycle_control #(.COUNT_W(4), .HALT_ON_ILLEGAL(1'b0)) dut2 (
    .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct3(funct3), .zero(zero),
    .state(state2), .pcwrite(pcwrite2), .pcwrite_br(pcwrite_br2), .irwrite(irwrite2),
    .memread(memread2), .memwrite(memwrite2), .regiwrite(regiwrite2), .memtoreg(memtoreg2),
    .alusrcb(alusrcb2), .aluop(aluop2), .halted(halted2), .illegal(illegal2), .instr_count(count2)
  );
  function automatic bit legal(input logic [6:0] op);
    return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 || op == 7'b0010011 || op == 7'b1100011;
  endfunction
  // strobes expected in each named state: {pcw, pcw_br, irw, memrd, memwr, regw, m2r, alusrcb, aluop, halted}
  function automatic logic [11:0] exp_sig(input logic [3:0] s, input logic r, input logic [6:0] op,
                                          input logic [2:0] f3, input logic z);
    logic br;
    br = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z);
    case (s)
      4'd0: return r ? {7'b1011000, 2'b01, 2'b00, 1'b0} : 12'd0;
      4'd2: return {7'b0000000, 2'b10, 2'b00, 1'b0};
      4'd3: return {7'b0001000, 2'b00, 2'b00, 1'b0};
      4'd4: return {7'b0000100, 2'b00, 2'b00, 1'b0};
      4'd5: return {7'b0000000, op == 7'b0010011 ? 2'b10 : 2'b00, 2'b10, 1'b0};
      4'd6: return {7'b0000010, 2'b00, 2'b00, 1'b0};
      4'd7: return {7'b0000011, 2'b00, 2'b00, 1'b0};
      4'd8: return {1'b0, br, 5'b00000, 2'b00, 2'b01, 1'b0};
      4'd9: return 12'd1;
      default: return 12'd0;
    endcase
  endfunction
  // states visited after FETCH for one instruction on the halting build
  function automatic sq_t seq_of(input logic [6:0] op);
    sq_t q;
    case (op)
      7'b0000011: q = {4'd1, 4'd2, 4'd3, 4'd7, 4'd0};
      7'b0100011: q = {4'd1, 4'd2, 4'd4, 4'd0};
      7'b0110011, 7'b0010011: q = {4'd1, 4'd5, 4'd6, 4'd0};
      7'b1100011: q = {4'd1, 4'd8, 4'd0};
      default: q = {4'd1, 4'd9};
    endcase
    return q;
  endfunction
  task automatic test_instr(input logic [6:0] op, input logic [2:0] f3, input logic z, input string tag);
    sq_t q;
    logic [11:0] e;
    q = seq_of(op);
    opcode = op; funct3 = f3; zero = z; run = 1'b1;
    #1;
    checks++;
    if ({state, sig} !== {4'd0, exp_sig(4'd0, 1'b1, op, f3, z)}) begin
      errors++; $display("FAIL %s fetch: got state %b sig %b, want 0000 %b", tag, state, sig, exp_sig(4'd0, 1'b1, op, f3, z));
    end
    foreach (q[i]) begin
      @(posedge clk); #1;
      e = exp_sig(q[i], 1'b1, op, f3, z);
      checks++;
      if (state !== q[i]) begin errors++; $display("FAIL %s step%0d state: got %b want %b", tag, i, state, q[i]); end
      checks++;
      if (sig !== e) begin errors++; $display("FAIL %s step%0d strobes: got %b want %b", tag, i, sig, e); end
      checks++;
      if ({state2, sig2} !== {q[i], e}) begin
        errors++; $display("FAIL %s step%0d dut2: got %b %b want %b %b", tag, i, state2, sig2, q[i], e);
      end
    end
    model_cnt++;
    checks++;
    if (instr_count !== 32'(model_cnt)) begin errors++; $display("FAIL %s count: got %0d want %0d", tag, instr_count, 32'(model_cnt)); end
    checks++;
    if (count2 !== 4'(model_cnt)) begin errors++; $display("FAIL %s count4: got %0d want %0d", tag, count2, 4'(model_cnt)); end
  endtask
  task automatic test_reset();
    rst = 1'b1; run = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({state, sig, illegal, instr_count} !== {4'd0, 12'd0, 1'b0, 32'd0}) begin
        errors++; $display("FAIL reset c%0d: got state %b sig %b ill %b cnt %0d want all zero", i, state, sig, illegal, instr_count);
      end
      checks++;
      if ({state2, sig2, count2} !== 20'd0) begin errors++; $display("FAIL reset2 c%0d: got %b %b %0d want zero", i, state2, sig2, count2); end
    end
  endtask
  task automatic test_idle(input int n);
    run = 1'b0;
    #1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({state, sig, instr_count} !== {4'd0, 12'd0, 32'(model_cnt)}) begin
        errors++; $display("FAIL idle c%0d: got state %b sig %b cnt %0d want 0000 0 %0d", i, state, sig, instr_count, 32'(model_cnt));
      end
    end
  endtask
  task automatic test_rtype();
    test_instr(7'b0110011, 3'($urandom), 1'($urandom), "rtype");
    test_instr(7'b0010011, 3'($urandom), 1'($urandom), "itype");
    test_instr(7'b0110011, 3'($urandom), 1'($urandom), "rtype_after_i");
  endtask
  task automatic test_load_store();
    test_instr(7'b0000011, 3'($urandom), 1'($urandom), "load");
    test_instr(7'b0100011, 3'($urandom), 1'($urandom), "store");
  endtask
  task automatic test_branch();
    test_instr(7'b1100011, 3'd0, 1'b1, "beq_taken");
    test_instr(7'b1100011, 3'd0, 1'b0, "beq_not");
    test_instr(7'b1100011, 3'd1, 1'b0, "bne_taken");
    test_instr(7'b1100011, 3'd1, 1'b1, "bne_not");
    test_instr(7'b1100011, 3'd2, 1'b1, "f3_010");
  endtask
  task automatic test_back_to_back(input int n);
    logic [6:0] ops [5] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};
    for (int i = 0; i < n; i++) begin
      test_instr(ops[$urandom_range(0, 4)], 3'($urandom), 1'($urandom), "random");
      if ($urandom_range(0, 3) == 0) test_idle($urandom_range(1, 3));
    end
  endtask
  task automatic test_illegal();
    logic [6:0] op;
    op = 7'b1111111;
    opcode = op; run = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({state, state2} !== {4'd1, 4'd1}) begin errors++; $display("FAIL illegal decode: got %b %b want 0001 0001", state, state2); end
    @(posedge clk); #1;
    checks++;
    if ({state, halted, illegal, sig} !== {4'd9, 1'b1, 1'b1, 12'd1}) begin
      errors++; $display("FAIL illegal halt: got state %b halted %b ill %b sig %b want 1001 1 1 %b", state, halted, illegal, sig, 12'd1);
    end
    checks++;
    if ({state2, illegal2} !== {4'd0, 1'b0}) begin errors++; $display("FAIL illegal nop: got state %b ill %b want 0000 0", state2, illegal2); end
    for (int i = 0; i < 10; i++) begin
      do op = 7'($urandom); while (legal(op));
      opcode = op;
      @(posedge clk); #1;
      checks++;
      if ({state, illegal, instr_count} !== {4'd9, 1'b1, 32'(model_cnt)}) begin
        errors++; $display("FAIL halt hold c%0d: got state %b ill %b cnt %0d want 1001 1 %0d", i, state, illegal, instr_count, 32'(model_cnt));
      end
      checks++;
      if (count2 !== 4'(model_cnt)) begin errors++; $display("FAIL nop count c%0d: got %0d want %0d", i, count2, 4'(model_cnt)); end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b0; model_cnt = 0;
    checks++;
    if ({state, halted, illegal, instr_count} !== {4'd0, 1'b0, 1'b0, 32'd0}) begin
      errors++; $display("FAIL illegal rst: got state %b halted %b ill %b cnt %0d want 0000 0 0 0", state, halted, illegal, instr_count);
    end
  endtask
  task automatic test_reset_midop();
    logic [3:0] q [3] = '{4'd1, 4'd2, 4'd3};
    opcode = 7'b0000011; run = 1'b1;
    foreach (q[i]) begin
      @(posedge clk); #1;
      checks++;
      if (state !== q[i]) begin errors++; $display("FAIL midop walk%0d: got %b want %b", i, state, q[i]); end
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b0; model_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({state, regiwrite, instr_count} !== {4'd0, 1'b0, 32'd0}) begin
        errors++; $display("FAIL midop rst c%0d: got state %b regw %b cnt %0d want 0000 0 0", i, state, regiwrite, instr_count);
      end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    test_reset();
    test_rtype();
    test_load_store();
    test_idle(3);
    test_branch();
    test_back_to_back(40);
    test_illegal();
    test_back_to_back(20);
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
